// File: rtl/test_pattern_pkg.sv
// ----------------------------------------------------------------------------
// test_pattern_pkg
// Shared types for the synthetic video source:
//   cmd_t          command codes sent to the memory controller
//   pattern_mode_t runtime pattern selection
//   state_t        sequencer states of test_pattern_generator
//   get_rgb_color  RGB565 palette used to build the colour-bar table
// ----------------------------------------------------------------------------
package test_pattern_pkg;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    FRAME_START = 2'd1,
    ROW_READY   = 2'd2,
    FRAME_END   = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    PM_BARS    = 2'd0,
    PM_RAMP    = 2'd1,
    PM_CHECKER = 2'd2,
    PM_SOLID   = 2'd3
  } pattern_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FRAME_START = 3'd1,
    ST_WAIT_CREDIT = 3'd2,
    ST_FILL_ROW    = 3'd3,
    ST_ROW_CMD     = 3'd4,
    ST_FRAME_END   = 3'd5
  } state_t;

  // Bar palette; indices past the table wrap so any bar count gets a colour.
  function automatic logic [15:0] get_rgb_color(input int unsigned idx);
    logic [15:0] c;
    case (idx % 10)
      0:       c = 16'hFFFF;  // white
      1:       c = 16'hFFE0;  // yellow
      2:       c = 16'h07FF;  // cyan
      3:       c = 16'h07E0;  // green
      4:       c = 16'hF81F;  // magenta
      5:       c = 16'hF800;  // red
      6:       c = 16'h001F;  // blue
      7:       c = 16'h0000;  // black
      8:       c = 16'hFD20;  // orange
      default: c = 16'h8410;  // mid grey
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tpg_pixel_engine.sv
// ----------------------------------------------------------------------------
// tpg_pixel_engine
// Produces one RGB565 pixel for column x_i of row y_i. One instance per pixel
// lane of a buffer word; lane LANE sees x = addr*PIXELS_PER_WORD + LANE.
// Ports:
//   clk_cam, reset_n  camera clock, async active-low reset
//   clear_i           re-arm the bar tracker at the start of a row
//   adv_i             step the bar tracker by one word (PIXELS_PER_WORD px)
//   x_i, y_i          pixel column / row
//   frame_count_i     completed frames, scrolls the checkerboard
//   mode_i, solid_i   latched pattern mode and solid colour
//   pixel_o           combinational pixel
// Bar tracker assumes LANE < BAR_WIDTH and PIXELS_PER_WORD <= BAR_WIDTH.
// ----------------------------------------------------------------------------
module tpg_pixel_engine
  import test_pattern_pkg::*;
#(
  parameter int FRAME_WIDTH     = 640,
  parameter int NUM_COLOR_BARS  = 10,
  parameter int PIXELS_PER_WORD = 2,
  parameter int GRAD_SHIFT      = 3,
  parameter int CHECKER_LOG2    = 5,
  parameter int FRAME_CNT_W     = 16,
  parameter int XW              = 11,
  parameter int YW              = 10,
  parameter int LANE            = 0
) (
  input  logic                   clk_cam,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic                   adv_i,
  input  logic [XW-1:0]          x_i,
  input  logic [YW-1:0]          y_i,
  input  logic [FRAME_CNT_W-1:0] frame_count_i,
  input  pattern_mode_t          mode_i,
  input  logic [15:0]            solid_i,
  output logic [15:0]            pixel_o
);

  localparam int BAR_WIDTH = FRAME_WIDTH / NUM_COLOR_BARS;
  localparam int BIW       = $clog2(NUM_COLOR_BARS + 1);
  localparam int PW        = $clog2(BAR_WIDTH + PIXELS_PER_WORD) + 1;

  logic [BIW-1:0] bar_idx_q, bar_idx_d;
  logic [PW-1:0]  bar_pos_q, bar_pos_d;
  logic [PW-1:0]  pos_next;
  logic [15:0]    bar_tab [NUM_COLOR_BARS];
  logic [15:0]    bar_px;
  logic [15:0]    ramp_px;
  logic [15:0]    chk_px;
  logic [5:0]     g6;
  logic [15:0]    yf;
  logic           chk_s;

  for (genvar i = 0; i < NUM_COLOR_BARS; i++) begin : g_bar
    assign bar_tab[i] = get_rgb_color(i);
  end

  // Bar index saturates at NUM_COLOR_BARS, which selects black for the
  // leftover columns when FRAME_WIDTH is not a multiple of the bar count.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_pos_d = bar_pos_q;
    pos_next  = bar_pos_q + PW'(PIXELS_PER_WORD);
    if (clear_i) begin
      bar_idx_d = '0;
      bar_pos_d = PW'(LANE);
    end else if (adv_i) begin
      if (pos_next >= PW'(BAR_WIDTH)) begin
        bar_pos_d = pos_next - PW'(BAR_WIDTH);
        if (bar_idx_q != BIW'(NUM_COLOR_BARS)) bar_idx_d = bar_idx_q + BIW'(1);
      end else begin
        bar_pos_d = pos_next;
      end
    end
  end

  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) begin
      bar_idx_q <= '0;
      bar_pos_q <= '0;
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_pos_q <= bar_pos_d;
    end
  end

  always_comb begin
    bar_px = 16'h0000;
    for (int i = 0; i < NUM_COLOR_BARS; i++) begin
      if (bar_idx_q == BIW'(i)) bar_px = bar_tab[i];
    end
  end

  assign g6      = 6'(x_i >> GRAD_SHIFT);
  assign ramp_px = {g6[5:1], g6, g6[5:1]};

  // Row offset by frame count, modulo 2**16, scrolls the board one row/frame.
  assign yf      = 16'(32'(y_i) + 32'(frame_count_i));
  assign chk_s   = 1'(x_i >> CHECKER_LOG2) ^ 1'(yf >> CHECKER_LOG2);
  assign chk_px  = chk_s ? 16'hFFFF : 16'h0000;

  always_comb begin
    case (mode_i)
      PM_BARS:    pixel_o = bar_px;
      PM_RAMP:    pixel_o = ramp_px;
      PM_CHECKER: pixel_o = chk_px;
      default:    pixel_o = solid_i;
    endcase
  end

endmodule

// File: rtl/test_pattern_generator.sv
// ----------------------------------------------------------------------------
// test_pattern_generator
// Synthetic camera source: fills ping-pong row buffers with RGB565 words and
// issues FRAME_START / ROW_READY / FRAME_END toward the memory controller.
// Ports:
//   clk_cam, reset_n     camera clock, async active-low reset
//   init_i               run while high; stops at the next frame boundary
//   mode_i, solid_color_i pattern select / solid colour, sampled at FRAME_START
//   cmd_valid_o, cmd_data_o, cmd_ready_i   command handshake
//   row_release_i        consumer freed one row buffer (returns a credit)
//   buf_we_o, buf_sel_o, buf_addr_o, buf_wdata_o   row-buffer write port
//   frame_count_o        completed frames, wraps
//   busy_o               high outside IDLE
//
//   state          | meaning
//   ---------------+-----------------------------------------------------
//   ST_IDLE        | stopped, waiting for init_i
//   ST_FRAME_START | FRAME_START pending; latches mode/solid, clears y
//   ST_WAIT_CREDIT | waiting for a free row buffer
//   ST_FILL_ROW    | one word per cycle into buffer buf_sel
//   ST_ROW_CMD     | ROW_READY pending; then flip buffer, next row
//   ST_FRAME_END   | FRAME_END pending; then bump frame count
// ----------------------------------------------------------------------------
module test_pattern_generator
  import test_pattern_pkg::*;
#(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int NUM_COLOR_BARS  = 10,
  parameter int PIXELS_PER_WORD = 2,
  parameter int GRAD_SHIFT      = 3,
  parameter int CHECKER_LOG2    = 5,
  parameter int FRAME_CNT_W     = 16,
  localparam int WORDS  = FRAME_WIDTH / PIXELS_PER_WORD,
  localparam int AW     = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int WORD_W = 16 * PIXELS_PER_WORD
) (
  input  logic                   clk_cam,
  input  logic                   reset_n,
  input  logic                   init_i,
  input  logic [1:0]             mode_i,
  input  logic [15:0]            solid_color_i,
  output logic                   cmd_valid_o,
  output logic [1:0]             cmd_data_o,
  input  logic                   cmd_ready_i,
  input  logic                   row_release_i,
  output logic                   buf_we_o,
  output logic                   buf_sel_o,
  output logic [AW-1:0]          buf_addr_o,
  output logic [WORD_W-1:0]      buf_wdata_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic                   busy_o
);

  localparam int XW = $clog2(FRAME_WIDTH) + 1;
  localparam int YW = $clog2(FRAME_HEIGHT) + 1;

  state_t                 state_q, state_d;
  logic [1:0]             credit_q, credit_d;
  logic [YW-1:0]          y_q, y_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   sel_q, sel_d;
  logic [FRAME_CNT_W-1:0] fc_q, fc_d;
  pattern_mode_t          mode_q, mode_d;
  logic [15:0]            solid_q, solid_d;
  logic                   we_q;
  logic [AW-1:0]          waddr_q;
  logic [WORD_W-1:0]      wdata_q;
  logic [15:0]            px [PIXELS_PER_WORD];
  logic [WORD_W-1:0]      word_c;
  logic                   take_credit;
  logic                   filling;

  assign filling     = (state_q == ST_FILL_ROW);
  assign take_credit = (state_q == ST_WAIT_CREDIT) && (credit_q != 2'd0);

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_data_o  = CMD_NONE;
    case (state_q)
      ST_FRAME_START: begin cmd_valid_o = 1'b1; cmd_data_o = FRAME_START; end
      ST_ROW_CMD:     begin cmd_valid_o = 1'b1; cmd_data_o = ROW_READY;   end
      ST_FRAME_END:   begin cmd_valid_o = 1'b1; cmd_data_o = FRAME_END;   end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    fc_d    = fc_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    case (state_q)
      ST_IDLE: if (init_i) state_d = ST_FRAME_START;
      ST_FRAME_START: begin
        if (cmd_ready_i) begin
          mode_d  = pattern_mode_t'(mode_i);
          solid_d = solid_color_i;
          y_d     = '0;
          state_d = ST_WAIT_CREDIT;
        end
      end
      ST_WAIT_CREDIT: begin
        addr_d = '0;
        if (credit_q != 2'd0) state_d = ST_FILL_ROW;
      end
      ST_FILL_ROW: begin
        addr_d = addr_q + AW'(1);
        if (addr_q == AW'(WORDS - 1)) state_d = ST_ROW_CMD;
      end
      ST_ROW_CMD: begin
        if (cmd_ready_i) begin
          sel_d   = ~sel_q;
          y_d     = y_q + YW'(1);
          state_d = (y_q == YW'(FRAME_HEIGHT - 1)) ? ST_FRAME_END : ST_WAIT_CREDIT;
        end
      end
      ST_FRAME_END: begin
        if (cmd_ready_i) begin
          fc_d    = fc_q + FRAME_CNT_W'(1);
          state_d = init_i ? ST_FRAME_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A release arriving in the same cycle a row claims a buffer cancels out;
  // releases beyond two outstanding buffers are dropped.
  always_comb begin
    credit_d = credit_q;
    if (take_credit && !row_release_i)
      credit_d = credit_q - 2'd1;
    else if (row_release_i && !take_credit && credit_q != 2'd2)
      credit_d = credit_q + 2'd1;
  end

  for (genvar n = 0; n < PIXELS_PER_WORD; n++) begin : g_lane
    logic [XW-1:0] x_lane;
    assign x_lane = XW'(32'(addr_q) * PIXELS_PER_WORD + n);

    tpg_pixel_engine #(
      .FRAME_WIDTH     (FRAME_WIDTH),
      .NUM_COLOR_BARS  (NUM_COLOR_BARS),
      .PIXELS_PER_WORD (PIXELS_PER_WORD),
      .GRAD_SHIFT      (GRAD_SHIFT),
      .CHECKER_LOG2    (CHECKER_LOG2),
      .FRAME_CNT_W     (FRAME_CNT_W),
      .XW              (XW),
      .YW              (YW),
      .LANE            (n)
    ) u_engine (
      .clk_cam       (clk_cam),
      .reset_n       (reset_n),
      .clear_i       (state_q == ST_WAIT_CREDIT),
      .adv_i         (filling),
      .x_i           (x_lane),
      .y_i           (y_q),
      .frame_count_i (fc_q),
      .mode_i        (mode_q),
      .solid_i       (solid_q),
      .pixel_o       (px[n])
    );
  end

  always_comb begin
    word_c = '0;
    for (int n = 0; n < PIXELS_PER_WORD; n++) word_c[16*n +: 16] = px[n];
  end

  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      credit_q <= 2'd2;
      y_q      <= '0;
      addr_q   <= '0;
      sel_q    <= 1'b0;
      fc_q     <= '0;
      mode_q   <= PM_BARS;
      solid_q  <= 16'h0000;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      fc_q     <= fc_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      // Write port is one cycle behind the fill counter; buf_sel only flips on
      // the ROW_READY handshake, which is always after the last word lands.
      we_q     <= filling;
      if (filling) begin
        waddr_q <= addr_q;
        wdata_q <= word_c;
      end
    end
  end

  assign buf_we_o      = we_q;
  assign buf_sel_o     = sel_q;
  assign buf_addr_o    = waddr_q;
  assign buf_wdata_o   = wdata_q;
  assign frame_count_o = fc_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_test_pattern_generator.sv
module tb_test_pattern_generator;

  localparam int FW = 8, FH = 2, NB = 4, PPW = 2, GS = 1, CL = 1;

  logic        clk_cam = 1'b0;
  logic        reset_n;
  logic        init, cmd_ready, row_release;
  logic [1:0]  mode;
  logic [15:0] solid;
  logic        cmd_valid;
  logic [1:0]  cmd_data;
  logic        buf_we, buf_sel;
  logic [1:0]  buf_addr;
  logic [31:0] buf_wdata;
  logic [15:0] frame_count;
  logic        busy;

  always #5 clk_cam = ~clk_cam;

  test_pattern_generator #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .NUM_COLOR_BARS(NB),
    .PIXELS_PER_WORD(PPW), .GRAD_SHIFT(GS), .CHECKER_LOG2(CL), .FRAME_CNT_W(16)
  ) dut (
    .clk_cam(clk_cam), .reset_n(reset_n), .init_i(init), .mode_i(mode),
    .solid_color_i(solid), .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data),
    .cmd_ready_i(cmd_ready), .row_release_i(row_release), .buf_we_o(buf_we),
    .buf_sel_o(buf_sel), .buf_addr_o(buf_addr), .buf_wdata_o(buf_wdata),
    .frame_count_o(frame_count), .busy_o(busy)
  );

  typedef struct packed {
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]       mode;
    logic [15:0]      solid;
    int               frame;
    logic [3:0][31:0] exp;
  } vec_t;

  wr_t        wr_q[$];
  logic [1:0] cmd_q[$];
  logic       auto_rel = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  vec_t       vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_cam);
    #1;
  endtask

  // Logs accepted commands and buffer writes; checks that a pending command
  // holds valid and data until accepted.
  initial begin : mon
    logic       pend;
    logic [1:0] pdata;
    pend  = 1'b0;
    pdata = 2'd0;
    forever begin
      @(negedge clk_cam);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) check("cmd_hold", {61'd0, cmd_valid, cmd_data}, {61'd0, 1'b1, pdata});
        if (buf_we) wr_q.push_back(wr_t'{buf_sel, buf_addr, buf_wdata});
        if (cmd_valid && cmd_ready) cmd_q.push_back(cmd_data);
        pend  = cmd_valid && !cmd_ready;
        pdata = cmd_data;
      end
    end
  end

  // Consumer model: frees a row buffer in the cycle its ROW_READY is accepted.
  initial begin : rel
    forever begin
      @(negedge clk_cam);
      if (auto_rel) row_release = cmd_valid && cmd_ready && (cmd_data == 2'd2);
    end
  end

  task automatic do_reset();
    reset_n     = 1'b0;
    auto_rel    = 1'b0;
    row_release = 1'b0;
    init        = 1'b0;
    cmd_ready   = 1'b0;
    mode        = 2'd0;
    solid       = 16'h0000;
    repeat (2) @(posedge clk_cam);
    #1;
    wr_q.delete();
    cmd_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_cmds(input int n, input string name);
    int b = 0;
    while (cmd_q.size() < n && b < 400) begin @(negedge clk_cam); b++; end
    if (cmd_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, %0d commands seen, %0d required", name, cmd_q.size(), n);
    end
  endtask

  task automatic wait_writes(input int n, input string name);
    int b = 0;
    while (wr_q.size() < n && b < 400) begin @(negedge clk_cam); b++; end
    if (wr_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, %0d writes seen, %0d required", name, wr_q.size(), n);
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] m, input logic [15:0] s, input int f,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    vecs[i].mode  = m;
    vecs[i].solid = s;
    vecs[i].frame = f;
    vecs[i].exp   = {w3, w2, w1, w0};
  endtask

  initial begin
    // Row-0 words: bars FFFF/FFE0/07FF/07E0 two pixels each; ramp g6 = x>>1
    // gives 0000,0020,0841,0861; checker 2-px squares, inverted when y+fc=2.
    set_vec(0, 2'd0, 16'h0000, 0, 32'hFFFFFFFF, 32'hFFE0FFE0, 32'h07FF07FF, 32'h07E007E0);
    set_vec(1, 2'd1, 16'h0000, 0, 32'h00000000, 32'h00200020, 32'h08410841, 32'h08610861);
    set_vec(2, 2'd2, 16'h0000, 0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    set_vec(3, 2'd2, 16'h0000, 2, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);
    set_vec(4, 2'd3, 16'hF800, 0, 32'hF800F800, 32'hF800F800, 32'hF800F800, 32'hF800F800);
    set_vec(5, 2'd3, 16'h1234, 1, 32'h12341234, 32'h12341234, 32'h12341234, 32'h12341234);
    set_vec(6, 2'd0, 16'h0000, 1, 32'hFFFFFFFF, 32'hFFE0FFE0, 32'h07FF07FF, 32'h07E007E0);

    reset_n = 1'b0; init = 1'b0; cmd_ready = 1'b0; row_release = 1'b0;
    mode = 2'd0; solid = 16'h0000;
    #1;
    check("reset_outputs",
          {8'd0, cmd_valid, cmd_data, buf_we, buf_sel, buf_addr, buf_wdata, frame_count, busy}, 64'd0);

    // Pattern table
    for (int i = 0; i < 7; i++) begin
      int f;
      int base;
      do_reset();
      mode      = vecs[i].mode;
      solid     = vecs[i].solid;
      cmd_ready = 1'b1;
      auto_rel  = 1'b1;
      init      = 1'b1;
      f         = vecs[i].frame;
      wait_cmds(4 * (f + 1) + 1, $sformatf("v%0d_wait", i));
      base = 8 * f;
      check($sformatf("v%0d_cmdseq", i),
            {56'd0, cmd_q[4*f], cmd_q[4*f+1], cmd_q[4*f+2], cmd_q[4*f+3]}, {56'd0, 8'b01_10_10_11});
      check($sformatf("v%0d_next_start", i), {62'd0, cmd_q[4*f+4]}, 64'd1);
      check($sformatf("v%0d_sel", i), {62'd0, wr_q[base].sel, wr_q[base+4].sel}, {62'd0, 2'b01});
      for (int w = 0; w < 4; w++)
        check($sformatf("v%0d_word%0d", i, w),
              {30'd0, wr_q[base+w].addr, wr_q[base+w].data}, {30'd0, 2'(w), vecs[i].exp[w]});
    end

    // FRAME_START back-pressure
    do_reset();
    init = 1'b1;
    begin
      int b = 0;
      while (!cmd_valid && b < 20) begin @(negedge clk_cam); b++; end
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_%0d", c), {60'd0, cmd_valid, cmd_data, buf_we}, {60'd0, 1'b1, 2'd1, 1'b0});
      @(negedge clk_cam);
    end
    step();
    cmd_ready = 1'b1;
    auto_rel  = 1'b1;
    wait_cmds(2, "stall_wait");
    check("stall_one_accept", {60'd0, cmd_q[0], cmd_q[1]}, {60'd0, 2'd1, 2'd2});

    // Credits: no releases at all
    do_reset();
    cmd_ready = 1'b1;
    init      = 1'b1;
    wait_cmds(5, "credit_wait");
    repeat (20) @(negedge clk_cam);
    check("credit_block", {59'd0, wr_q.size() == 8, buf_we, busy, frame_count[1:0]},
          {59'd0, 1'b1, 1'b0, 1'b1, 2'd1});
    check("credit_sel", {62'd0, wr_q[0].sel, wr_q[4].sel}, {62'd0, 2'b01});
    step();
    row_release = 1'b1;
    step();
    row_release = 1'b0;
    wait_cmds(6, "credit_resume");
    check("credit_resume", {61'd0, wr_q.size() == 12, wr_q[8].sel, cmd_q[5] == 2'd2},
          {61'd0, 1'b1, 1'b0, 1'b1});
    repeat (20) @(negedge clk_cam);
    check("credit_reblock", {63'd0, wr_q.size() == 12}, 64'd1);

    // init dropped mid-row; solid colour changed mid-frame
    do_reset();
    mode      = 2'd3;
    solid     = 16'hF800;
    cmd_ready = 1'b1;
    auto_rel  = 1'b1;
    init      = 1'b1;
    wait_writes(1, "stop_wait");
    step();
    init  = 1'b0;
    solid = 16'h0000;
    mode  = 2'd0;
    begin
      int b = 0;
      while (busy && b < 200) begin @(negedge clk_cam); b++; end
    end
    check("stop_busy", {63'd0, busy}, 64'd0);
    check("stop_cmds", {52'd0, 4'(cmd_q.size()), cmd_q[0], cmd_q[1], cmd_q[2], cmd_q[3]},
          {52'd0, 4'd4, 8'b01_10_10_11});
    check("stop_fc", {48'd0, frame_count}, 64'd1);
    begin
      logic ok;
      ok = (wr_q.size() == 8);
      foreach (wr_q[k]) if (wr_q[k].data !== 32'hF800F800) ok = 1'b0;
      check("stop_solid", {63'd0, ok}, 64'd1);
    end
    repeat (10) @(negedge clk_cam);
    check("stop_stays_idle", {62'd0, cmd_q.size() == 4, busy}, {62'd0, 2'b10});

    // Asynchronous reset during FILL_ROW of frame 1, row 1
    do_reset();
    mode      = 2'd3;
    solid     = 16'hABCD;
    cmd_ready = 1'b1;
    auto_rel  = 1'b1;
    init      = 1'b1;
    wait_writes(13, "areset_wait");
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_outputs",
          {8'd0, cmd_valid, cmd_data, buf_we, buf_sel, buf_addr, buf_wdata, frame_count, busy}, 64'd0);
    repeat (2) @(posedge clk_cam);
    #1;
    wr_q.delete();
    cmd_q.delete();
    reset_n = 1'b1;
    wait_writes(1, "restart_wait");
    check("restart_state", {45'd0, wr_q[0].sel, frame_count, cmd_q[0]}, {45'd0, 1'b0, 16'd0, 2'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
